// File: rtl/gf8_divider_if.sv
// Request/result bundle for the GF(2^M) divider.
// Handshake: start is taken only while the divider is idle (busy=0, done=0); done pulses once per accepted start.
interface gf8_divider_if #(parameter int M = 3);
  logic         start;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         busy;
  logic         done;
  logic [M-1:0] q;
  logic         dz;
  logic [2:0]   dbg_state;

  modport master (output start, a, b, input busy, done, q, dz, dbg_state);
  modport slave  (input start, a, b, output busy, done, q, dz, dbg_state);
endinterface

// File: rtl/gf8_divider.sv
// Sequential GF(2^M) divider: q = a * b^(2^M-2), built on one bit-serial MSB-first multiplier
// that is reused for every square and product of the exponentiation schedule.
module gf8_divider #(
  parameter int         M    = 3,
  parameter logic [M:0] POLY = 4'b1011
) (
  input  logic         Clk,
  input  logic         nRst,
  gf8_divider_if.slave bus
);
  localparam int CW = $clog2(M);
  localparam int RW = CW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MULA, FIN} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  a_reg, b_reg, sq, acc, p, p_nxt, mx, my;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rnd;
  logic          phase;
  logic          mul_last;
  logic [M:0]    sh, red;

  // Operand routing: phase 0 squares sq, phase 1 folds the new square into acc.
  always_comb begin
    mx = '0;
    my = '0;
    case (state)
      SQR: begin
        mx = phase ? acc : sq;
        my = sq;
      end
      MULA: begin
        mx = a_reg;
        my = acc;
      end
      default: ;
    endcase
  end

  always_comb begin
    sh       = {p, 1'b0} ^ {1'b0, (my[cnt] ? mx : '0)};
    red      = sh[M] ? (sh ^ POLY) : sh;
    p_nxt    = red[M-1:0];
    mul_last = (cnt == '0);
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.b == '0) ? FIN : LOAD;
      LOAD: begin
        bus.busy  = 1'b1;
        state_nxt = SQR;
      end
      SQR: begin
        bus.busy = 1'b1;
        if (mul_last && phase && rnd == RW'(M - 1)) state_nxt = MULA;
      end
      MULA: begin
        bus.busy = 1'b1;
        if (mul_last) state_nxt = FIN;
      end
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.dbg_state = state;

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      sq     <= '0;
      acc    <= '0;
      p      <= '0;
      cnt    <= '0;
      rnd    <= '0;
      phase  <= 1'b0;
      bus.q  <= '0;
      bus.dz <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          a_reg <= bus.a;
          b_reg <= bus.b;
          if (bus.b == '0) begin
            bus.q  <= '0;
            bus.dz <= 1'b1;
          end
        end
        LOAD: begin
          sq    <= b_reg;
          acc   <= M'(1);
          rnd   <= RW'(1);
          phase <= 1'b0;
          cnt   <= CW'(M - 1);
          p     <= '0;
        end
        SQR, MULA: begin
          if (mul_last) begin
            p   <= '0;
            cnt <= CW'(M - 1);
            if (state == MULA) begin
              bus.q  <= p_nxt;
              bus.dz <= 1'b0;
            end else if (!phase) begin
              sq    <= p_nxt;
              phase <= 1'b1;
            end else begin
              acc   <= p_nxt;
              phase <= 1'b0;
              rnd   <= rnd + RW'(1);
            end
          end else begin
            p   <= p_nxt;
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
